// File: rtl/eda_regional_max_cfg_pkg.sv
// Shared types and defaults for the configurable regional-maximum engine.
// The defaults come from the CFG_* macros when they are defined and fall back to a 6x6, 8-bit image otherwise.
`ifndef CFG_M
`define CFG_M 6
`endif
`ifndef CFG_N
`define CFG_N 6
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 3
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 3
`endif

package eda_regional_max_cfg_pkg;
  localparam int DEF_M           = `CFG_M;
  localparam int DEF_N           = `CFG_N;
  localparam int DEF_PIXEL_WIDTH = `CFG_PIXEL_WIDTH;
  localparam int DEF_I_WIDTH     = `CFG_I_WIDTH;
  localparam int DEF_J_WIDTH     = `CFG_J_WIDTH;

  typedef enum logic [2:0] {IDLE, INIT, SWEEP, CHECK, DONE} state_t;

  localparam logic CONN4 = 1'b0;
  localparam logic CONN8 = 1'b1;

  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

  typedef struct packed {
    logic [DEF_I_WIDTH-1:0] i;
    logic [DEF_J_WIDTH-1:0] j;
  } coord_t;
endpackage

// File: rtl/eda_rmax_neighbor_eval.sv
// Combinational kill decision for one pixel from its 3x3 neighbourhood.
// Neighbour order: 0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE.
module eda_rmax_neighbor_eval
  import eda_regional_max_cfg_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic [PIXEL_WIDTH-1:0]      center,
  input  logic [7:0][PIXEL_WIDTH-1:0] nbr,
  input  logic [7:0]                  nbr_flag,
  input  logic [7:0]                  nbr_valid,
  input  logic                        conn8,
  output logic                        kill
);
  // N, W, E and S are the only neighbours under 4-connectivity
  localparam logic [7:0] MASK4 = 8'b0101_1010;

  logic [7:0] hit;
  logic [7:0] mask;

  assign mask = (conn8 == CONN8) ? 8'hFF : MASK4;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hit
      assign hit[gi] = (nbr[gi] > center) || ((nbr[gi] == center) && !nbr_flag[gi]);
    end
  endgenerate

  assign kill = |(hit & nbr_valid & mask);
endmodule

// File: rtl/eda_regional_max_cfg.sv
// Regional-maximum engine: in-place flag sweeps over a register-array image, repeated until no flag changes.
// The flags left set at the end mark every pixel that belongs to a plateau with strictly lower surroundings.
module eda_regional_max_cfg
  import eda_regional_max_cfg_pkg::*;
#(
  parameter int M           = DEF_M,
  parameter int N           = DEF_N,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int I_WIDTH     = DEF_I_WIDTH,
  parameter int J_WIDTH     = DEF_J_WIDTH,
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
  parameter int PASS_WIDTH  = $clog2(M * N + 2)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   start,
  input  logic                   conn8,
  output logic                   busy,
  output logic                   done,
  output logic [PASS_WIDTH-1:0]  pass_count,
  output logic [M-1:0][N-1:0]    matrix_output
);
  localparam logic [I_WIDTH:0]   M_LIM  = (I_WIDTH + 1)'(M);
  localparam logic [J_WIDTH:0]   N_LIM  = (J_WIDTH + 1)'(N);
  localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);
  localparam int DI [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  localparam int DJ [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  state_t                 state_reg;
  logic                   conn8_reg;
  logic                   changed_reg;
  logic [PASS_WIDTH-1:0]  pass_reg;
  logic [M-1:0][N-1:0]    flags_reg;
  logic [M-1:0][N-1:0]    result_reg;
  logic [I_WIDTH-1:0]     cur_i_reg;
  logic [J_WIDTH-1:0]     cur_j_reg;
  logic [PIXEL_WIDTH-1:0] img_reg [M][N];

  logic [I_WIDTH-1:0] wr_i;
  logic [J_WIDTH-1:0] wr_j;
  logic               wr_ok;

  assign {wr_i, wr_j} = wr_addr;
  assign wr_ok = write_en && (state_reg == IDLE) &&
                 ({1'b0, wr_i} < M_LIM) && ({1'b0, wr_j} < N_LIM);

  logic [7:0][PIXEL_WIDTH-1:0] nbr_val;
  logic [7:0]                  nbr_flag;
  logic [7:0]                  nbr_valid;
  logic                        kill;

  // Offsets are added with two guard bits: the top bit flags a -1 underflow.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nbr
      localparam logic [I_WIDTH+1:0] OFF_I = (I_WIDTH + 2)'(DI[gi]);
      localparam logic [J_WIDTH+1:0] OFF_J = (J_WIDTH + 2)'(DJ[gi]);
      logic [I_WIDTH+1:0] ni;
      logic [J_WIDTH+1:0] nj;
      logic [I_WIDTH-1:0] si;
      logic [J_WIDTH-1:0] sj;

      assign ni = {2'b00, cur_i_reg} + OFF_I;
      assign nj = {2'b00, cur_j_reg} + OFF_J;
      assign nbr_valid[gi] = !ni[I_WIDTH+1] && !nj[J_WIDTH+1] &&
                             (ni[I_WIDTH:0] < M_LIM) && (nj[J_WIDTH:0] < N_LIM);
      assign si = nbr_valid[gi] ? ni[I_WIDTH-1:0] : '0;
      assign sj = nbr_valid[gi] ? nj[J_WIDTH-1:0] : '0;
      assign nbr_val[gi]  = img_reg[si][sj];
      assign nbr_flag[gi] = flags_reg[si][sj];
    end
  endgenerate

  eda_rmax_neighbor_eval #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_eval (
    .center    (img_reg[cur_i_reg][cur_j_reg]),
    .nbr       (nbr_val),
    .nbr_flag  (nbr_flag),
    .nbr_valid (nbr_valid),
    .conn8     (conn8_reg),
    .kill      (kill)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      conn8_reg   <= 1'b0;
      changed_reg <= 1'b0;
      pass_reg    <= '0;
      flags_reg   <= '0;
      result_reg  <= '0;
      cur_i_reg   <= '0;
      cur_j_reg   <= '0;
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          img_reg[i][j] <= '0;
        end
      end
    end else begin
      if (wr_ok) begin
        img_reg[wr_i][wr_j] <= pixel_in;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= INIT;
            conn8_reg <= conn8;
          end
        end
        INIT: begin
          flags_reg   <= '1;
          changed_reg <= 1'b0;
          pass_reg    <= '0;
          cur_i_reg   <= '0;
          cur_j_reg   <= '0;
          state_reg   <= SWEEP;
        end
        SWEEP: begin
          if (flags_reg[cur_i_reg][cur_j_reg] && kill) begin
            flags_reg[cur_i_reg][cur_j_reg] <= 1'b0;
            changed_reg <= 1'b1;
          end
          if (cur_j_reg == J_LAST) begin
            cur_j_reg <= '0;
            if (cur_i_reg == I_LAST) begin
              cur_i_reg <= '0;
              state_reg <= CHECK;
            end else begin
              cur_i_reg <= cur_i_reg + 1'b1;
            end
          end else begin
            cur_j_reg <= cur_j_reg + 1'b1;
          end
        end
        CHECK: begin
          if (pass_reg != '1) begin
            pass_reg <= pass_reg + 1'b1;
          end
          if (changed_reg) begin
            changed_reg <= 1'b0;
            state_reg   <= SWEEP;
          end else begin
            // Flags are final here, so the map is already valid while done is high.
            result_reg <= flags_reg;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign pass_count    = pass_reg;
  assign matrix_output = result_reg;
endmodule

// File: tb/tb_eda_regional_max_cfg.sv
// Self-checking bench for eda_regional_max_cfg: table-driven image runs plus hand sequences for mid-run corner cases.
module tb_eda_regional_max_cfg;
  localparam int M = 6;
  localparam int N = 6;
  localparam int PW = 8;
  localparam int AW = 6;
  localparam int PASSW = $clog2(M * N + 2);
  localparam int NV = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic write_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] pixel_in = '0;
  logic start = 1'b0;
  logic conn8 = 1'b0;
  logic busy;
  logic done;
  logic [PASSW-1:0] pass_count;
  logic [M-1:0][N-1:0] matrix_output;
  logic [M*N-1:0] map_flat;

  assign map_flat = matrix_output;

  always #5 clk = ~clk;

  eda_regional_max_cfg dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .wr_addr       (wr_addr),
    .pixel_in      (pixel_in),
    .start         (start),
    .conn8         (conn8),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .matrix_output (matrix_output)
  );

  typedef struct {
    logic [PW-1:0]  base;
    int             nov;
    int             oi [5];
    int             oj [5];
    logic [PW-1:0]  ov [5];
    logic           c8;
    logic [M*N-1:0] map;
    int             passes;
    string          name;
  } vec_t;

  typedef struct {
    logic [M*N-1:0] map;
    int             passes;
    string          name;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  exp_t mon_e;
  int n_checks = 0;
  int n_pass = 0;
  int busy_cycles = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;

  function automatic void check(string name, logic ok, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  function automatic int bp(int i, int j);
    return i * N + j;
  endfunction

  // Scoreboard side: every done pops one expectation pushed at start time.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (prev_done) check("busy_drop_after_done", !busy, 64'(busy), 64'd0);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1'b0, 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_map"}, map_flat == mon_e.map, 64'(map_flat), 64'(mon_e.map));
          if (mon_e.passes > 0)
            check({mon_e.name, "_passes"}, int'(pass_count) == mon_e.passes,
                  64'(pass_count), 64'(mon_e.passes));
          check({mon_e.name, "_latency"}, busy_cycles == 2 + int'(pass_count) * (M * N + 1),
                64'(busy_cycles), 64'(2 + int'(pass_count) * (M * N + 1)));
          $display("run %s: map=0x%09h passes=%0d busy_cycles=%0d",
                   mon_e.name, map_flat, pass_count, busy_cycles);
        end
      end
      prev_done = done;
    end
  end

  task automatic wr(int i, int j, logic [PW-1:0] v);
    @(negedge clk);
    write_en = 1'b1;
    wr_addr  = {3'(i), 3'(j)};
    pixel_in = v;
  endtask

  task automatic wr_end();
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        wr(i, j, v.base);
    for (int k = 0; k < v.nov; k++) wr(v.oi[k], v.oj[k], v.ov[k]);
    wr_end();
  endtask

  task automatic start_run(logic c, logic [M*N-1:0] map, int passes, string name);
    exp_t e;
    @(negedge clk);
    busy_cycles = 0;
    start = 1'b1;
    conn8 = c;
    e.map = map;
    e.passes = passes;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 1'b0, 64'(lat), 64'd0);
    @(negedge clk);
  endtask

  task automatic set_vec(int k, logic [PW-1:0] base, logic c8, int passes, string name);
    vecs[k].base = base;
    vecs[k].nov = 0;
    vecs[k].c8 = c8;
    vecs[k].map = '0;
    vecs[k].passes = passes;
    vecs[k].name = name;
  endtask

  task automatic add_ov(int k, int i, int j, logic [PW-1:0] v);
    vecs[k].oi[vecs[k].nov] = i;
    vecs[k].oj[vecs[k].nov] = j;
    vecs[k].ov[vecs[k].nov] = v;
    vecs[k].nov++;
  endtask

  initial begin
    int lat;
    int d0;
    logic [M*N-1:0] m;

    set_vec(0, 8'h7F, 1'b0, 1, "const7f");
    vecs[0].map = '1;
    set_vec(1, 8'd10, 1'b0, 0, "single50");
    add_ov(1, 3, 2, 8'd50);
    vecs[1].map[bp(3, 2)] = 1'b1;
    set_vec(2, 8'd20, 1'b0, 0, "plateau");
    add_ov(2, 1, 1, 8'd90); add_ov(2, 1, 2, 8'd90); add_ov(2, 2, 1, 8'd90);
    add_ov(2, 2, 2, 8'd90); add_ov(2, 4, 4, 8'd90);
    vecs[2].map[bp(1, 1)] = 1'b1; vecs[2].map[bp(1, 2)] = 1'b1; vecs[2].map[bp(2, 1)] = 1'b1;
    vecs[2].map[bp(2, 2)] = 1'b1; vecs[2].map[bp(4, 4)] = 1'b1;
    set_vec(3, 8'd5, 1'b1, 0, "corners8");
    add_ov(3, 0, 0, 8'd9); add_ov(3, 0, 5, 8'd9); add_ov(3, 5, 0, 8'd9); add_ov(3, 5, 5, 8'd9);
    vecs[3].map[bp(0, 0)] = 1'b1; vecs[3].map[bp(0, 5)] = 1'b1;
    vecs[3].map[bp(5, 0)] = 1'b1; vecs[3].map[bp(5, 5)] = 1'b1;
    set_vec(4, 8'd0, 1'b0, 0, "diag_conn4");
    add_ov(4, 2, 2, 8'd60); add_ov(4, 3, 3, 8'd80);
    vecs[4].map[bp(2, 2)] = 1'b1; vecs[4].map[bp(3, 3)] = 1'b1;
    set_vec(5, 8'd0, 1'b1, 0, "diag_conn8");
    add_ov(5, 2, 2, 8'd60); add_ov(5, 3, 3, 8'd80);
    vecs[5].map[bp(3, 3)] = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("reset_done", done == 1'b0, 64'(done), 64'd0);
    check("reset_pass_count", pass_count == '0, 64'(pass_count), 64'd0);
    check("reset_matrix", map_flat == '0, 64'(map_flat), 64'd0);
    reset_n = 1'b1;

    for (int t = 0; t < NV; t++) begin
      load(vecs[t]);
      start_run(vecs[t].c8, vecs[t].map, vecs[t].passes, vecs[t].name);
      wait_done(lat);
      if (t == 0) begin
        check("const_done_cycle", lat == 39, 64'(lat), 64'd39);
        check("const_busy_window", busy_cycles == 39, 64'(busy_cycles), 64'd39);
      end
    end

    // Raising (2,3) above the plateau must dissolve the whole plateau over several passes.
    load(vecs[2]);
    wr(2, 3, 8'd95);
    wr_end();
    m = '0;
    m[bp(2, 3)] = 1'b1;
    m[bp(4, 4)] = 1'b1;
    start_run(1'b0, m, 0, "plateau_raised");
    wait_done(lat);

    // conn8 toggled while busy must not change the latched 4-connectivity result.
    load(vecs[4]);
    start_run(1'b0, vecs[4].map, 0, "conn8_toggle");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      conn8 = ~conn8;
    end
    conn8 = 1'b1;
    wait_done(lat);
    conn8 = 1'b0;

    // Write and start during a run are both dropped.
    load(vecs[1]);
    start_run(1'b0, vecs[1].map, 0, "busy_write_start");
    repeat (8) @(negedge clk);
    write_en = 1'b1;
    wr_addr  = '0;
    pixel_in = 8'd255;
    start    = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    start    = 1'b0;
    wait_done(lat);
    d0 = done_seen;
    repeat (60) @(negedge clk);
    check("single_done_pulse", done_seen == d0, 64'(done_seen), 64'(d0));
    check("idle_after_run", busy == 1'b0, 64'(busy), 64'd0);
    start_run(1'b0, vecs[1].map, 0, "memory_unchanged");
    wait_done(lat);

    // Reset mid-sweep aborts at once and clears the result.
    start_run(1'b0, vecs[1].map, 0, "aborted");
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("abort_done", done == 1'b0, 64'(done), 64'd0);
    check("abort_matrix", map_flat == '0, 64'(map_flat), 64'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    load(vecs[1]);
    start_run(1'b0, vecs[1].map, 0, "after_abort");
    wait_done(lat);
    check("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
